// File: rtl/result_scorer.sv
// result_scorer: counts classified images against golden labels fetched
// from an external label memory, then divides matches by total to give
// an integer accuracy percentage for on-chip self-test.
module result_scorer #(
    parameter int NUM_TESTS = 750,
    parameter int CLASS_W   = 4,
    parameter int LABEL_W   = 8,
    parameter int CNT_W     = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CLASS_W-1:0] mnist_class,
    input  logic               single_test_done,
    input  logic               done,
    output logic [CNT_W-1:0]   label_addr,
    input  logic [LABEL_W-1:0] label_data,
    output logic [CNT_W-1:0]   test_count,
    output logic [CNT_W-1:0]   accepted_count,
    output logic [6:0]         accuracy,
    output logic               accuracy_valid,
    output logic               overflow,
    output logic               busy
);

    localparam int DIV_W  = CNT_W + 7;
    localparam int STEP_W = $clog2(DIV_W);
    localparam logic [CNT_W-1:0]  MAX_COUNT = CNT_W'(NUM_TESTS);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DIV_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        CMP,
        DIV,
        REPORT
    } state_t;

    state_t             state_q, state_d;
    logic               std_prev_q, std_prev_d;
    logic               done_prev_q, done_prev_d;
    logic [CNT_W-1:0]   test_count_q, test_count_d;
    logic [CNT_W-1:0]   accepted_count_q, accepted_count_d;
    logic [CLASS_W-1:0] cls_q, cls_d;
    logic [CLASS_W-1:0] hold_cls_q, hold_cls_d;
    logic               res_pend_q, res_pend_d;
    logic               done_pend_q, done_pend_d;
    logic               overflow_q, overflow_d;
    logic [6:0]         accuracy_q, accuracy_d;
    logic               accuracy_valid_q, accuracy_valid_d;
    logic [DIV_W-1:0]   num_q, num_d;
    logic [CNT_W:0]     rem_q, rem_d;
    logic [STEP_W-1:0]  step_q, step_d;

    logic               std_edge;
    logic               done_edge;
    logic               result_evt;
    logic               label_match;
    logic               go_div;
    logic [CNT_W:0]     rem_shift;
    logic [CNT_W:0]     rem_diff;
    logic [DIV_W-1:0]   num_next;
    logic [DIV_W-1:0]   acc_ext;
    logic [DIV_W-1:0]   num_load;

    // Next-state logic: edge detection, scoring, divider steps and restart handling
    always_comb begin
        state_d          = state_q;
        std_prev_d       = single_test_done;
        done_prev_d      = done;
        test_count_d     = test_count_q;
        accepted_count_d = accepted_count_q;
        cls_d            = cls_q;
        hold_cls_d       = hold_cls_q;
        res_pend_d       = res_pend_q;
        done_pend_d      = done_pend_q;
        overflow_d       = overflow_q;
        accuracy_d       = accuracy_q;
        accuracy_valid_d = accuracy_valid_q;
        num_d            = num_q;
        rem_d            = rem_q;
        step_d           = step_q;
        go_div           = 1'b0;

        std_edge    = single_test_done & ~std_prev_q;
        done_edge   = done & ~done_prev_q;
        result_evt  = std_edge | res_pend_q;
        label_match = (label_data[CLASS_W-1:0] == cls_q) && ((label_data >> CLASS_W) == '0);
        rem_shift   = {rem_q[CNT_W-1:0], num_q[DIV_W-1]};
        rem_diff    = rem_shift - {1'b0, test_count_q};
        num_next    = {num_q[DIV_W-2:0], 1'b0};

        case (state_q)
            RUN: begin
                if (result_evt && (test_count_q != MAX_COUNT)) begin
                    state_d = CMP;
                    if (res_pend_q) begin
                        cls_d      = hold_cls_q;
                        res_pend_d = std_edge;
                        if (std_edge) begin
                            hold_cls_d = mnist_class;
                        end
                    end else begin
                        cls_d = mnist_class;
                    end
                    if (done_edge) begin
                        done_pend_d = 1'b1;
                    end
                end else begin
                    if (result_evt) begin
                        overflow_d = 1'b1;
                        res_pend_d = 1'b0;
                    end
                    if (done_edge) begin
                        go_div = 1'b1;
                    end
                end
            end
            CMP: begin
                test_count_d = test_count_q + CNT_W'(1);
                if (label_match) begin
                    accepted_count_d = accepted_count_q + CNT_W'(1);
                end
                if (std_edge) begin
                    res_pend_d = 1'b1;
                    hold_cls_d = mnist_class;
                end
                if (done_pend_q || done_edge) begin
                    go_div = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            DIV: begin
                if (rem_shift >= {1'b0, test_count_q}) begin
                    rem_d       = rem_diff;
                    num_next[0] = 1'b1;
                end else begin
                    rem_d = rem_shift;
                end
                num_d  = num_next;
                step_d = step_q + STEP_W'(1);
                if (step_q == LAST_STEP) begin
                    state_d          = REPORT;
                    accuracy_d       = num_next[6:0];
                    accuracy_valid_d = 1'b1;
                end
            end
            default: begin
            end
        endcase

        acc_ext  = DIV_W'(accepted_count_d);
        num_load = (acc_ext << 6) + (acc_ext << 5) + (acc_ext << 2);

        if (go_div) begin
            done_pend_d = 1'b0;
            res_pend_d  = 1'b0;
            if (test_count_d == '0) begin
                state_d          = REPORT;
                accuracy_d       = '0;
                accuracy_valid_d = 1'b1;
            end else begin
                state_d = DIV;
                num_d   = num_load;
                rem_d   = '0;
                step_d  = '0;
            end
        end

        if (start) begin
            state_d          = RUN;
            test_count_d     = '0;
            accepted_count_d = '0;
            overflow_d       = 1'b0;
            accuracy_d       = '0;
            accuracy_valid_d = 1'b0;
            res_pend_d       = 1'b0;
            done_pend_d      = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            std_prev_q       <= 1'b0;
            done_prev_q      <= 1'b0;
            test_count_q     <= '0;
            accepted_count_q <= '0;
            cls_q            <= '0;
            hold_cls_q       <= '0;
            res_pend_q       <= 1'b0;
            done_pend_q      <= 1'b0;
            overflow_q       <= 1'b0;
            accuracy_q       <= '0;
            accuracy_valid_q <= 1'b0;
            num_q            <= '0;
            rem_q            <= '0;
            step_q           <= '0;
        end else begin
            state_q          <= state_d;
            std_prev_q       <= std_prev_d;
            done_prev_q      <= done_prev_d;
            test_count_q     <= test_count_d;
            accepted_count_q <= accepted_count_d;
            cls_q            <= cls_d;
            hold_cls_q       <= hold_cls_d;
            res_pend_q       <= res_pend_d;
            done_pend_q      <= done_pend_d;
            overflow_q       <= overflow_d;
            accuracy_q       <= accuracy_d;
            accuracy_valid_q <= accuracy_valid_d;
            num_q            <= num_d;
            rem_q            <= rem_d;
            step_q           <= step_d;
        end
    end

    assign label_addr     = test_count_q;
    assign test_count     = test_count_q;
    assign accepted_count = accepted_count_q;
    assign accuracy       = accuracy_q;
    assign accuracy_valid = accuracy_valid_q;
    assign overflow       = overflow_q;
    assign busy           = (state_q != IDLE) && (state_q != REPORT);

endmodule

// File: tb/tb_result_scorer.sv
// tb_result_scorer: directed bench for result_scorer with a scoreboard of
// expected run results, plus a second instance with a small NUM_TESTS to
// exercise the overflow path.
module tb_result_scorer;

    localparam int CLASS_W    = 4;
    localparam int LABEL_W    = 8;
    localparam int CNT_W      = 10;
    localparam int NUM_TESTS  = 750;
    localparam int OVF_TESTS  = 4;
    localparam int DIV_CYCLES = CNT_W + 7;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [CLASS_W-1:0] mnist_class;
    logic               single_test_done;
    logic               done;

    logic [CNT_W-1:0]   label_addr, label_addr_o;
    logic [LABEL_W-1:0] label_data, label_data_o;
    logic [CNT_W-1:0]   test_count, test_count_o;
    logic [CNT_W-1:0]   accepted_count, accepted_count_o;
    logic [6:0]         accuracy, accuracy_o;
    logic               accuracy_valid, accuracy_valid_o;
    logic               overflow, overflow_o;
    logic               busy, busy_o;

    logic [LABEL_W-1:0] label_mem [0:1023];

    typedef struct {
        int tc;
        int ac;
        int acc;
    } exp_t;

    exp_t sb_q[$];

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    int model_tc, model_ac;
    int ovf_tc, ovf_ac, ovf_flag;

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    result_scorer #(
        .NUM_TESTS(NUM_TESTS), .CLASS_W(CLASS_W), .LABEL_W(LABEL_W), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .mnist_class(mnist_class),
        .single_test_done(single_test_done), .done(done),
        .label_addr(label_addr), .label_data(label_data),
        .test_count(test_count), .accepted_count(accepted_count),
        .accuracy(accuracy), .accuracy_valid(accuracy_valid),
        .overflow(overflow), .busy(busy)
    );

    result_scorer #(
        .NUM_TESTS(OVF_TESTS), .CLASS_W(CLASS_W), .LABEL_W(LABEL_W), .CNT_W(CNT_W)
    ) u_ovf (
        .clk(clk), .rst(rst), .start(start), .mnist_class(mnist_class),
        .single_test_done(single_test_done), .done(done),
        .label_addr(label_addr_o), .label_data(label_data_o),
        .test_count(test_count_o), .accepted_count(accepted_count_o),
        .accuracy(accuracy_o), .accuracy_valid(accuracy_valid_o),
        .overflow(overflow_o), .busy(busy_o)
    );

    // Label memory with a one-cycle synchronous read port per instance
    always @(posedge clk) begin
        label_data   <= label_mem[label_addr];
        label_data_o <= label_mem[label_addr_o];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        model_tc = 0;
        model_ac = 0;
        ovf_tc   = 0;
        ovf_ac   = 0;
        ovf_flag = 0;
    endtask

    task automatic startPulse();
        start = 1'b1;
        step();
        start = 1'b0;
        modelReset();
    endtask

    // Update both reference models for one classified image
    task automatic modelResult(input logic [CLASS_W-1:0] cls);
        if (model_tc < NUM_TESTS) begin
            if (label_mem[model_tc] == LABEL_W'(cls)) model_ac++;
            model_tc++;
        end
        if (ovf_tc < OVF_TESTS) begin
            if (label_mem[ovf_tc] == LABEL_W'(cls)) ovf_ac++;
            ovf_tc++;
        end else begin
            ovf_flag = 1;
        end
    endtask

    // One image: raise single_test_done for 'hold' cycles, then idle two cycles
    task automatic applyStimulus(input logic [CLASS_W-1:0] cls, input int hold);
        mnist_class      = cls;
        single_test_done = 1'b1;
        modelResult(cls);
        repeat (hold) step();
        single_test_done = 1'b0;
        step();
        step();
    endtask

    task automatic pushExpected();
        exp_t e;
        e.tc  = model_tc;
        e.ac  = model_ac;
        e.acc = (model_tc == 0) ? 0 : (100 * model_ac) / model_tc;
        sb_q.push_back(e);
    endtask

    // Called just after the DIV-entry (or REPORT-entry) edge; waits for the report
    task automatic waitReport(input string tag, input int exp_cycles);
        int   n;
        exp_t e;
        n = 0;
        while (!accuracy_valid && n < 200) begin
            step();
            n++;
        end
        done = 1'b0;
        checkOutput({tag, "_valid"}, 32'(accuracy_valid), 32'd1);
        checkOutput({tag, "_latency"}, 32'(n), 32'(exp_cycles));
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checkOutput({tag, "_test_count"}, 32'(test_count), 32'(e.tc));
            checkOutput({tag, "_accepted"}, 32'(accepted_count), 32'(e.ac));
            checkOutput({tag, "_accuracy"}, 32'(accuracy), 32'(e.acc));
        end
        step();
    endtask

    task automatic finishRun(input string tag, input int exp_cycles);
        pushExpected();
        done = 1'b1;
        step();
        if (exp_cycles > 0) checkOutput({tag, "_busy_div"}, 32'(busy), 32'd1);
        waitReport(tag, exp_cycles);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_test_count"}, 32'(test_count), 32'd0);
        checkOutput({tag, "_accepted"}, 32'(accepted_count), 32'd0);
        checkOutput({tag, "_accuracy"}, 32'(accuracy), 32'd0);
        checkOutput({tag, "_valid"}, 32'(accuracy_valid), 32'd0);
        checkOutput({tag, "_overflow"}, 32'(overflow), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_label_addr"}, 32'(label_addr), 32'd0);
        checkOutput({tag, "_ovf_inst_flag"}, 32'(overflow_o), 32'd0);
    endtask

    // Directed sequence of scenarios
    initial begin
        rst              = 1'b1;
        start            = 1'b0;
        single_test_done = 1'b0;
        done             = 1'b0;
        mnist_class      = '0;
        modelReset();
        for (int i = 0; i < 1024; i++) label_mem[i] = '0;

        step();
        step();
        checkResetState("reset");
        rst = 1'b0;
        step();

        // Basic scoring: labels {3,7,1,0}, classes 3,7,2,0
        label_mem[0] = 8'd3;
        label_mem[1] = 8'd7;
        label_mem[2] = 8'd1;
        label_mem[3] = 8'd0;
        startPulse();
        checkOutput("basic_busy_run", 32'(busy), 32'd1);
        applyStimulus(4'd3, 3);
        applyStimulus(4'd7, 3);
        applyStimulus(4'd2, 3);
        applyStimulus(4'd0, 3);
        checkOutput("basic_label_addr", 32'(label_addr), 32'd4);
        finishRun("basic", DIV_CYCLES);

        // Full run with flooring: 500 of 750 match
        for (int i = 0; i < NUM_TESTS; i++) label_mem[i] = LABEL_W'(i % 10);
        startPulse();
        for (int i = 0; i < NUM_TESTS; i++) begin
            applyStimulus(CLASS_W'((i < 500) ? (i % 10) : ((i % 10) + 1) % 10), 1);
        end
        finishRun("floor", DIV_CYCLES);

        // Full run, all matching
        startPulse();
        for (int i = 0; i < NUM_TESTS; i++) applyStimulus(CLASS_W'(i % 10), 1);
        finishRun("full", DIV_CYCLES);

        // No results at all: report straight away with accuracy 0
        startPulse();
        finishRun("zero", 0);

        // Overflow on the small instance: fifth result not scored
        for (int i = 0; i < 5; i++) label_mem[i] = LABEL_W'(i + 1);
        startPulse();
        for (int i = 0; i < 4; i++) applyStimulus(CLASS_W'(i + 1), 2);
        checkOutput("ovf_before_flag", 32'(overflow_o), 32'(ovf_flag));
        checkOutput("ovf_before_count", 32'(test_count_o), 32'(ovf_tc));
        applyStimulus(4'd5, 2);
        checkOutput("ovf_flag", 32'(overflow_o), 32'(ovf_flag));
        checkOutput("ovf_count", 32'(test_count_o), 32'(ovf_tc));
        checkOutput("ovf_accepted", 32'(accepted_count_o), 32'(ovf_ac));
        checkOutput("ovf_label_addr", 32'(label_addr_o), 32'd4);
        checkOutput("ovf_main_flag", 32'(overflow), 32'd0);
        checkOutput("ovf_main_count", 32'(test_count), 32'(model_tc));

        // done rising during CMP; first label has nonzero upper bits
        label_mem[0] = 8'h15;
        label_mem[1] = 8'd6;
        startPulse();
        applyStimulus(4'd5, 2);
        checkOutput("upper_bits_accepted", 32'(accepted_count), 32'd0);
        mnist_class      = 4'd6;
        single_test_done = 1'b1;
        modelResult(4'd6);
        step();
        done = 1'b1;
        step();
        single_test_done = 1'b0;
        pushExpected();
        checkOutput("collide_busy", 32'(busy), 32'd1);
        checkOutput("collide_count", 32'(test_count), 32'd2);
        waitReport("collide", DIV_CYCLES);

        // start pulsed in the middle of a divide
        startPulse();
        applyStimulus(4'd5, 1);
        done = 1'b1;
        step();
        repeat (5) step();
        done  = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        modelReset();
        checkOutput("restart_count", 32'(test_count), 32'd0);
        checkOutput("restart_accepted", 32'(accepted_count), 32'd0);
        checkOutput("restart_valid", 32'(accuracy_valid), 32'd0);
        checkOutput("restart_busy", 32'(busy), 32'd1);
        applyStimulus(4'd7, 1);
        checkOutput("restart_rescore", 32'(test_count), 32'd1);

        // rst in the middle of a run
        applyStimulus(4'd6, 1);
        rst = 1'b1;
        step();
        checkResetState("midrst");
        rst = 1'b0;
        step();

        if (sb_q.size() != 0) $display("[TB] scoreboard left with %0d entries", sb_q.size());
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/result_scorer.md
Name: result_scorer

Overview:
- Hardware scoreboard on the result side of the Neural_network interface.
- Watches mnist_class, single_test_done and done from the network.
- For each completed classification it fetches the golden label from an external label memory, compares it with the class, and counts totals and matches.
- On done it computes the integer accuracy percentage with a sequential divider, so on-chip self-test needs no testbench.

Parameters:
- NUM_TESTS, 750, number of labels in memory; results beyond this are not scored.
- CLASS_W, 4, width of mnist_class.
- LABEL_W, 8, width of a label memory word; only the low CLASS_W bits are compared, and the upper bits must be zero for a match.
- CNT_W, 10, width of the counters and of label_addr (must satisfy 2^CNT_W > NUM_TESTS).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; clears the counters and arms scoring.
- mnist_class  in  CLASS_W  network output class.
- single_test_done  in  1  network per-image completion; may be high for one or more cycles.
- done  in  1  network end-of-run indication (level or pulse).
- label_addr  out  CNT_W  label memory read address.
- label_data  in  LABEL_W  label memory read data; synchronous read, 1-cycle latency.
- test_count  out  CNT_W  images scored.
- accepted_count  out  CNT_W  images whose class matched the label.
- accuracy  out  7  floor(100*accepted_count/test_count), range 0..100.
- accuracy_valid  out  1  high while accuracy is valid.
- overflow  out  1  sticky; set when a result arrives after NUM_TESTS have been scored.
- busy  out  1  high in any state other than IDLE and REPORT.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE.
  - All counters, accuracy, accuracy_valid, overflow, the pending flag and the edge-detect registers are 0.
  - label_addr=0.
  - rst overrides every other input on that edge, including mid-run and mid-divide.
- Edge detection: registered copies of single_test_done and done. An event is a 0->1 transition, so a multi-cycle high counts once.
- label_addr is always equal to test_count (registered). label_data for the current image is therefore valid from one cycle after test_count changes.
- States:
  - IDLE: outputs hold. start -> RUN, clearing counters, overflow and accuracy_valid.
  - RUN:
    - On a single_test_done edge, capture mnist_class into cls_q and go to CMP.
    - If test_count==NUM_TESTS, set overflow instead and stay in RUN.
    - On a done edge (with no pending compare) go to DIV.
  - CMP (1 cycle):
    - If label_data[CLASS_W-1:0]==cls_q and the upper label bits are 0, accepted_count+=1.
    - test_count+=1.
    - Then go to DIV if done_pend is set, otherwise RUN.
  - DIV:
    - Restoring shift-subtract division: numerator 100*accepted_count, width CNT_W+7; divisor test_count.
    - Exactly CNT_W+7 cycles, then go to REPORT.
    - If test_count==0, skip the division, set accuracy=0 and go straight to REPORT.
  - REPORT:
    - accuracy_valid=1; accuracy holds.
    - start clears the results and goes to RUN.
    - single_test_done and done are ignored.
- done edge while in CMP: set done_pend. DIV is entered immediately after CMP completes, so the last result is always scored before the divide.
- single_test_done edge while in CMP: set res_pend and capture the class into a one-deep holding register. It is processed as an event in the cycle after CMP returns to RUN.
- start while in RUN, CMP or DIV: restarts scoring at once. Counters are cleared and any pending flags are dropped.
- The multiply by 100 is done as (acc<<6)+(acc<<5)+(acc<<2); no DSP is required.

Test Plan:
- Reset check: rst held 2 cycles -> every output 0, busy=0, label_addr=0.
- Basic scoring: labels {3,7,1,0}, start, then classes 3,7,2,0, each single_test_done held 3 cycles; done -> test_count=4, accepted_count=3; accuracy_valid rises exactly CNT_W+7 cycles after DIV entry; accuracy=75.
- Flooring and full count: 750 results with 500 matches -> accuracy=66. All 750 matching -> accuracy=100.
- Zero tests: start then done with no results -> accuracy=0, accuracy_valid=1 one cycle after the done edge is detected.
- Overflow: NUM_TESTS=4 (override) and 5 results -> test_count=4, overflow=1; the fifth result is not counted.
- Collisions and restart:
  - done rising in the same cycle as CMP -> the last image is still counted before DIV.
  - start pulsed mid-DIV -> counters reset to 0, state RUN, accuracy_valid=0.
  - rst mid-RUN -> all outputs return to reset values on the next edge.
